square_wave_meter: RTL and testbench

SQUARE_WAVE_METER -- requirements
Module: square_wave_meter

---
 rtl/square_wave_meter.sv | 123 ++++++++++++
 tb/tb_square_wave_meter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/square_wave_meter.sv
// Measures period and high time of an asynchronous square wave in clk48 cycles,
// publishing each result through a valid/ready register pair with sticky overrun.
module square_wave_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 96000000
) (
  input  logic             clk48,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             tracking,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2, r_sync3;
  logic             r_rise, r_fall;
  logic [CNT_W-1:0] r_period, r_high;
  logic             r_highRun;
  logic             r_tracking, r_timeout;
  logic [CNT_W-1:0] r_measPeriod, r_measHigh;
  logic             r_measValid, r_overrun;
  logic             w_publish;

  always_ff @(posedge clk48) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
      r_fall  <= ~r_sync2 & r_sync3;
    end
  end

  assign w_publish = (r_state == TRACK) && r_rise;

  // Counters restart at 1 because the cycle holding the detected rise is already
  // part of the new period; the timeout compare caps them so they cannot wrap.
  always_ff @(posedge clk48) begin
    if (reset) begin
      r_state    <= IDLE;
      r_period   <= '0;
      r_high     <= '0;
      r_highRun  <= 1'b0;
      r_tracking <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rise) begin
            r_state    <= TRACK;
            r_tracking <= 1'b1;
            r_period   <= CNT_W'(1);
            r_high     <= CNT_W'(1);
            r_highRun  <= 1'b1;
          end
        end
        TRACK: begin
          if (r_rise) begin
            r_period  <= CNT_W'(1);
            r_high    <= CNT_W'(1);
            r_highRun <= 1'b1;
          end else if (r_period == TIMEOUT_VAL) begin
            r_state    <= IDLE;
            r_tracking <= 1'b0;
            r_timeout  <= 1'b1;
            r_highRun  <= 1'b0;
          end else begin
            r_period <= r_period + CNT_W'(1);
            if (r_highRun) begin
              if (r_fall) r_highRun <= 1'b0;
              else        r_high    <= r_high + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tracking <= 1'b0;
        end
      endcase
    end
  end

  // A new result always wins over an accept; overrun only marks unread data lost.
  always_ff @(posedge clk48) begin
    if (reset) begin
      r_measPeriod <= '0;
      r_measHigh   <= '0;
      r_measValid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_publish) begin
      r_measPeriod <= r_period;
      r_measHigh   <= r_high;
      r_measValid  <= 1'b1;
      if (r_measValid && !meas_ready) r_overrun <= 1'b1;
    end else if (r_measValid && meas_ready) begin
      r_measValid <= 1'b0;
    end
  end

  assign meas_period = r_measPeriod;
  assign meas_high   = r_measHigh;
  assign meas_valid  = r_measValid;
  assign tracking    = r_tracking;
  assign timeout     = r_timeout;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_square_wave_meter.sv
// Drives square_wave_meter with directed and random waveforms and compares every
// output each cycle against a timing model built from the sig_in transition times.
module tb_square_wave_meter;

  localparam int CW = 32;
  localparam int TO = 1000;
  localparam int LAT = 3;

  logic          clk48 = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic          meas_ready = 1'b0;
  logic [CW-1:0] meas_period, meas_high;
  logic          meas_valid, tracking, timeout, overrun;

  int checks = 0;
  int errors = 0;

  square_wave_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk48(clk48), .reset(reset), .sig_in(sig_in),
    .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .tracking(tracking), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk48 = ~clk48;

  // hist[k] is the sig_in level sampled k clock edges ago
  bit hist[0:LAT+1];
  int t = 0;
  bit mTrack = 0;
  int mRise = 0;
  int mFall = -1;
  int ePer = 0, eHigh = 0;
  bit eValid = 0, eTimeout = 0, eOver = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  // Result timing derived purely from when rises/falls of sig_in were sampled.
  function automatic void modelEdge(input bit r, input bit s, input bit rdy);
    bit rise, fall, pub;
    int pPer, pHigh;
    t++;
    for (int k = LAT + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    eTimeout = 0;
    if (r) begin
      for (int k = 0; k <= LAT + 1; k++) hist[k] = 0;
      mTrack = 0; mFall = -1;
      ePer = 0; eHigh = 0; eValid = 0; eOver = 0;
      return;
    end
    rise = hist[LAT] && !hist[LAT+1];
    fall = !hist[LAT] && hist[LAT+1];
    pub = 0; pPer = 0; pHigh = 0;
    if (rise) begin
      if (mTrack) begin
        pub = 1;
        pPer = t - mRise;
        pHigh = (mFall < 0) ? pPer : mFall - mRise;
      end
      mTrack = 1; mRise = t; mFall = -1;
    end else if (mTrack) begin
      if (fall && mFall < 0) mFall = t;
      if (t - mRise == TO) begin
        eTimeout = 1;
        mTrack = 0;
      end
    end
    if (pub) begin
      if (eValid && !rdy) eOver = 1;
      eValid = 1; ePer = pPer; eHigh = pHigh;
    end else if (eValid && rdy) begin
      eValid = 0;
    end
  endfunction

  // ready modes: 0 low, 1 high, 2 random, 3 high only on cycles that load a result
  function automatic bit pickReady(input int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return mTrack && hist[LAT-1] && !hist[LAT];
    endcase
  endfunction

  task automatic applyStimulus(input bit r, input bit s, input int mode);
    bit rdy;
    rdy = pickReady(mode);
    reset = r; sig_in = s; meas_ready = rdy;
    @(posedge clk48);
    modelEdge(r, s, rdy);
    @(negedge clk48);
    checkOutput("meas_valid", 64'(meas_valid), 64'(eValid));
    checkOutput("meas_period", 64'(meas_period), 64'(ePer));
    checkOutput("meas_high", 64'(meas_high), 64'(eHigh));
    checkOutput("tracking", 64'(tracking), 64'(mTrack));
    checkOutput("timeout", 64'(timeout), 64'(eTimeout));
    checkOutput("overrun", 64'(overrun), 64'(eOver));
  endtask

  task automatic hold(input int n, input bit s, input int mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s, mode);
  endtask

  task automatic wave(input int hi, input int lo, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      hold(hi, 1'b1, mode);
      hold(lo, 1'b0, mode);
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0);
  endtask

  initial begin
    doReset(3);
    hold(5, 1'b0, 1);

    $display("[TB] 48-cycle period, 24 high, ready held high");
    wave(24, 24, 5, 1);

    $display("[TB] signal held low until timeout");
    hold(TO + 60, 1'b0, 1);

    $display("[TB] results lost while ready low");
    doReset(2);
    wave(24, 24, 1, 0);
    wave(30, 30, 1, 0);
    hold(24, 1'b1, 0);
    hold(LAT + 1, 1'b0, 0);
    hold(1, 1'b0, 1);
    hold(10, 1'b0, 0);

    $display("[TB] accept on the same cycle as a new result");
    doReset(2);
    wave(12, 18, 5, 3);

    $display("[TB] reset in the middle of a period");
    wave(24, 24, 2, 1);
    hold(20, 1'b1, 1);
    doReset(2);
    wave(24, 24, 4, 1);

    $display("[TB] one-cycle pulses every 10 cycles");
    wave(1, 9, 8, 1);

    $display("[TB] random waveforms");
    for (int seg = 0; seg < 80; seg++) begin
      int hi, lo;
      hi = $urandom_range(1, 50);
      lo = (seg == 40) ? TO + 50 : $urandom_range(1, 50);
      hold(hi, 1'b1, 2);
      hold(lo, 1'b0, 2);
      if (seg == 60) doReset(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
